// File: rtl/fir_channel_scheduler_if.sv
// Handshake bundle between channel sources, the shared FIR core, the result sink and the scheduler.
// slave = scheduler side, master = source/core/sink side.
interface fir_channel_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_CH     = 4
);
    localparam int unsigned CH_WIDTH = $clog2(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] iv_ch_din;
    logic [NUM_CH-1:0]            iv_ch_valid;
    logic [NUM_CH-1:0]            ov_ch_ready;
    logic [DATA_WIDTH-1:0]        ov_fir_din;
    logic [CH_WIDTH-1:0]          ov_fir_bank;
    logic                         o_fir_din_valid;
    logic                         i_fir_ready;
    logic [DATA_WIDTH-1:0]        iv_fir_dout;
    logic                         i_fir_dout_valid;
    logic                         o_fir_dout_ready;
    logic [DATA_WIDTH-1:0]        ov_dout;
    logic [CH_WIDTH-1:0]          ov_dout_ch;
    logic                         o_dout_valid;
    logic                         i_dout_ready;

    modport slave (
        input  iv_ch_din, iv_ch_valid, i_fir_ready, iv_fir_dout, i_fir_dout_valid, i_dout_ready,
        output ov_ch_ready, ov_fir_din, ov_fir_bank, o_fir_din_valid, o_fir_dout_ready,
               ov_dout, ov_dout_ch, o_dout_valid
    );

    modport master (
        output iv_ch_din, iv_ch_valid, i_fir_ready, iv_fir_dout, i_fir_dout_valid, i_dout_ready,
        input  ov_ch_ready, ov_fir_din, ov_fir_bank, o_fir_din_valid, o_fir_dout_ready,
               ov_dout, ov_dout_ch, o_dout_valid
    );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler time-sharing one FIR core among NUM_CH channels.
// Optional WAIT_RES watchdog with o_timeout pulse: define SCHED_TIMEOUT_EN.
module fir_channel_scheduler #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_CH     = 4
`ifdef SCHED_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    fir_channel_scheduler_if.slave bus,
`ifdef SCHED_TIMEOUT_EN
    output logic                   o_timeout,
`endif
    output logic                   o_busy
);
    localparam int unsigned CH_WIDTH = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fir_din_q, fir_din_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [CH_WIDTH-1:0]   last_q, last_d;
    logic                  fir_vld_q, fir_vld_d;
    logic                  dout_vld_q, dout_vld_d;

    logic [CH_WIDTH-1:0]   grant_c;
    logic [CH_WIDTH-1:0]   idx_c;
    logic                  found_c;
    logic [NUM_CH-1:0]     ch_ready_c;
    logic                  take_c;
    logic [DATA_WIDTH-1:0] sample_c;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
`endif

    // Rotating-priority search starting just after the last granted channel.
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx_c = CH_WIDTH'((32'(last_q) + k) % NUM_CH);
            if (!found_c && bus.iv_ch_valid[idx_c]) begin
                found_c = 1'b1;
                grant_c = idx_c;
            end
        end
    end

    always_comb begin
        sample_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant_c == CH_WIDTH'(k)) sample_c = bus.iv_ch_din[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Readies are combinational and forced low while frozen or in reset.
    always_comb begin
        ch_ready_c = '0;
        if (state_q == IDLE && i_en && i_rst_n && found_c) ch_ready_c = NUM_CH'(1) << grant_c;
    end
    assign take_c = |(ch_ready_c & bus.iv_ch_valid);

    always_comb begin
        state_d    = state_q;
        fir_din_d  = fir_din_q;
        dout_d     = dout_q;
        ch_d       = ch_q;
        last_d     = last_q;
        fir_vld_d  = fir_vld_q;
        dout_vld_d = dout_vld_q;
`ifdef SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
`endif
        if (i_en) begin
`ifdef SCHED_TIMEOUT_EN
            tmo_d = 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (take_c) begin
                        fir_din_d = sample_c;
                        ch_d      = grant_c;
                        last_d    = grant_c;
                        fir_vld_d = 1'b1;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.i_fir_ready) begin
                        fir_vld_d = 1'b0;
                        state_d   = WAIT_RES;
`ifdef SCHED_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
                WAIT_RES: begin
                    if (bus.i_fir_dout_valid) begin
                        dout_d     = bus.iv_fir_dout;
                        dout_vld_d = 1'b1;
                        state_d    = DELIVER;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
`endif
                end
                DELIVER: begin
                    // Return to IDLE without granting this cycle.
                    if (bus.i_dout_ready) begin
                        dout_vld_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            fir_din_q  <= '0;
            dout_q     <= '0;
            ch_q       <= '0;
            last_q     <= CH_WIDTH'(NUM_CH - 1);
            fir_vld_q  <= 1'b0;
            dout_vld_q <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fir_din_q  <= fir_din_d;
            dout_q     <= dout_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            fir_vld_q  <= fir_vld_d;
            dout_vld_q <= dout_vld_d;
`ifdef SCHED_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign bus.ov_ch_ready      = ch_ready_c;
    assign bus.ov_fir_din       = fir_din_q;
    assign bus.ov_fir_bank      = ch_q;
    assign bus.o_fir_din_valid  = fir_vld_q;
    assign bus.o_fir_dout_ready = (state_q == WAIT_RES) && i_en && i_rst_n;
    assign bus.ov_dout          = dout_q;
    assign bus.ov_dout_ch       = ch_q;
    assign bus.o_dout_valid     = dout_vld_q;
    assign o_busy               = (state_q != IDLE);
`ifdef SCHED_TIMEOUT_EN
    assign o_timeout            = tmo_q;
`endif
endmodule
